// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, control codes, port identifiers and the
// legal-code check used by the arbiter to flag unsupported operations.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_NAND = 4'b1101;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic logic ctrl_is_legal(input logic [CTRL_W-1:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_NAND: ctrl_is_legal = 1'b1;
      default:                    ctrl_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit combinational ALU shared by both arbiter ports.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  // Operation decode; SLT is a signed compare returned in bit 0.
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_NAND: result_o = ~(a_i & b_i);
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port front end for the shared ALU: an issue stage (E)
// drives the ALU and a response stage (W) holds the result for its owner.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_valid_i,
  output logic              p0_req_ready_o,
  input  logic [DATA_W-1:0] p0_src1_i,
  input  logic [DATA_W-1:0] p0_src2_i,
  input  logic [CTRL_W-1:0] p0_ctrl_i,
  output logic              p0_resp_valid_o,
  input  logic              p0_resp_ready_i,
  output logic [DATA_W-1:0] p0_result_o,
  output logic              p0_zero_o,
  output logic              p0_err_o,
  input  logic              p1_req_valid_i,
  output logic              p1_req_ready_o,
  input  logic [DATA_W-1:0] p1_src1_i,
  input  logic [DATA_W-1:0] p1_src2_i,
  input  logic [CTRL_W-1:0] p1_ctrl_i,
  output logic              p1_resp_valid_o,
  input  logic              p1_resp_ready_i,
  output logic [DATA_W-1:0] p1_result_o,
  output logic              p1_zero_o,
  output logic              p1_err_o
);

  logic              r_e_valid;
  port_e             r_e_owner;
  logic [DATA_W-1:0] r_e_src1;
  logic [DATA_W-1:0] r_e_src2;
  logic [CTRL_W-1:0] r_e_ctrl;
  logic              r_e_err;

  logic              r_w_valid;
  port_e             r_w_owner;
  logic [DATA_W-1:0] r_w_result;
  logic              r_w_zero;
  logic              r_w_err;

  port_e             r_last;

  logic              w_w_free;
  logic              w_e_adv;
  logic              w_e_can_accept;
  port_e             w_grant;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_src1;
  logic [DATA_W-1:0] w_sel_src2;
  logic [CTRL_W-1:0] w_sel_ctrl;
  logic              w_sel_legal;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_w_result;
  logic              w_unused_alu_zero;

  assign w_w_free       = ~r_w_valid |
                          ((r_w_owner == PORT1) ? p1_resp_ready_i : p0_resp_ready_i);
  assign w_e_adv        = r_e_valid & w_w_free;
  assign w_e_can_accept = ~r_e_valid | w_w_free;

  // Round-robin pick: a lone request wins, a tie goes to the port not granted last.
  always_comb begin
    w_grant = PORT0;
    if (p0_req_valid_i && p1_req_valid_i) begin
      w_grant = (r_last == PORT1) ? PORT0 : PORT1;
    end else if (p1_req_valid_i) begin
      w_grant = PORT1;
    end else begin
      w_grant = PORT0;
    end
  end

  assign w_accept       = (p0_req_valid_i | p1_req_valid_i) & w_e_can_accept;
  assign p0_req_ready_o = p0_req_valid_i & (w_grant == PORT0) & w_e_can_accept;
  assign p1_req_ready_o = p1_req_valid_i & (w_grant == PORT1) & w_e_can_accept;

  // Operand mux for the winning port.
  always_comb begin
    w_sel_src1 = p0_src1_i;
    w_sel_src2 = p0_src2_i;
    w_sel_ctrl = p0_ctrl_i;
    if (w_grant == PORT1) begin
      w_sel_src1 = p1_src1_i;
      w_sel_src2 = p1_src2_i;
      w_sel_ctrl = p1_ctrl_i;
    end else begin
      w_sel_src1 = p0_src1_i;
      w_sel_src2 = p0_src2_i;
      w_sel_ctrl = p0_ctrl_i;
    end
  end

  assign w_sel_legal = ctrl_is_legal(w_sel_ctrl);

  alu u_alu (
    .a_i      (r_e_src1),
    .b_i      (r_e_src2),
    .ctrl_i   (r_e_ctrl),
    .result_o (w_alu_result),
    .zero_o   (w_unused_alu_zero)
  );

  // Illegal codes reach the ALU as AND, but their response is forced to zero.
  assign w_w_result = r_e_err ? '0 : w_alu_result;

  // Issue stage and last-grant pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_e_valid <= 1'b0;
      r_e_owner <= PORT0;
      r_e_src1  <= '0;
      r_e_src2  <= '0;
      r_e_ctrl  <= ALU_AND;
      r_e_err   <= 1'b0;
      r_last    <= PORT1;
    end else begin
      if (w_accept) begin
        r_e_valid <= 1'b1;
        r_e_owner <= w_grant;
        r_e_src1  <= w_sel_src1;
        r_e_src2  <= w_sel_src2;
        r_e_ctrl  <= w_sel_legal ? w_sel_ctrl : ALU_AND;
        r_e_err   <= ~w_sel_legal;
        r_last    <= w_grant;
      end else if (w_e_adv) begin
        r_e_valid <= 1'b0;
      end
    end
  end

  // Response stage: captured from E when it frees, cleared once consumed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_w_valid  <= 1'b0;
      r_w_owner  <= PORT0;
      r_w_result <= '0;
      r_w_zero   <= 1'b0;
      r_w_err    <= 1'b0;
    end else begin
      if (w_e_adv) begin
        r_w_valid  <= 1'b1;
        r_w_owner  <= r_e_owner;
        r_w_result <= w_w_result;
        r_w_zero   <= (w_w_result == '0);
        r_w_err    <= r_e_err;
      end else if (w_w_free) begin
        r_w_valid  <= 1'b0;
      end
    end
  end

  assign p0_resp_valid_o = r_w_valid & (r_w_owner == PORT0);
  assign p1_resp_valid_o = r_w_valid & (r_w_owner == PORT1);
  assign p0_result_o     = p0_resp_valid_o ? r_w_result : '0;
  assign p1_result_o     = p1_resp_valid_o ? r_w_result : '0;
  assign p0_zero_o       = p0_resp_valid_o & r_w_zero;
  assign p1_zero_o       = p1_resp_valid_o & r_w_zero;
  assign p0_err_o        = p0_resp_valid_o & r_w_err;
  assign p1_err_o        = p1_resp_valid_o & r_w_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed expectations.
module tb_alu_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        p0_req_valid_i, p0_req_ready_o, p0_resp_valid_o, p0_resp_ready_i;
  logic [31:0] p0_src1_i, p0_src2_i, p0_result_o;
  logic [3:0]  p0_ctrl_i;
  logic        p0_zero_o, p0_err_o;
  logic        p1_req_valid_i, p1_req_ready_o, p1_resp_valid_o, p1_resp_ready_i;
  logic [31:0] p1_src1_i, p1_src2_i, p1_result_o;
  logic [3:0]  p1_ctrl_i;
  logic        p1_zero_o, p1_err_o;

  int n_chk;
  int n_err;

  alu_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .p0_req_valid_i  (p0_req_valid_i),
    .p0_req_ready_o  (p0_req_ready_o),
    .p0_src1_i       (p0_src1_i),
    .p0_src2_i       (p0_src2_i),
    .p0_ctrl_i       (p0_ctrl_i),
    .p0_resp_valid_o (p0_resp_valid_o),
    .p0_resp_ready_i (p0_resp_ready_i),
    .p0_result_o     (p0_result_o),
    .p0_zero_o       (p0_zero_o),
    .p0_err_o        (p0_err_o),
    .p1_req_valid_i  (p1_req_valid_i),
    .p1_req_ready_o  (p1_req_ready_o),
    .p1_src1_i       (p1_src1_i),
    .p1_src2_i       (p1_src2_i),
    .p1_ctrl_i       (p1_ctrl_i),
    .p1_resp_valid_o (p1_resp_valid_o),
    .p1_resp_ready_i (p1_resp_ready_i),
    .p1_result_o     (p1_result_o),
    .p1_zero_o       (p1_zero_o),
    .p1_err_o        (p1_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic exp_g;
    n_chk = 0;
    n_err = 0;
    rst_i = 1'b0;
    p0_req_valid_i = 1'b0; p0_src1_i = 32'd0; p0_src2_i = 32'd0; p0_ctrl_i = 4'd0;
    p1_req_valid_i = 1'b0; p1_src1_i = 32'd0; p1_src2_i = 32'd0; p1_ctrl_i = 4'd0;
    p0_resp_ready_i = 1'b1; p1_resp_ready_i = 1'b1;
    #12;
    chk("rst_p0_valid",  {31'd0, p0_resp_valid_o}, 32'd0);
    chk("rst_p1_valid",  {31'd0, p1_resp_valid_o}, 32'd0);
    chk("rst_p0_result", p0_result_o, 32'd0);
    chk("rst_p1_ready",  {31'd0, p1_req_ready_o}, 32'd0);
    rst_i = 1'b1;
    step();

    // Port 0 alone: ADD 5+7
    p0_req_valid_i = 1'b1; p0_src1_i = 32'd5; p0_src2_i = 32'd7; p0_ctrl_i = 4'b0010;
    #1;
    chk("t1_p0_ready", {31'd0, p0_req_ready_o}, 32'd1);
    chk("t1_p1_ready", {31'd0, p1_req_ready_o}, 32'd0);
    step();
    p0_req_valid_i = 1'b0;
    chk("t1_lat1_valid", {31'd0, p0_resp_valid_o}, 32'd0);
    step();
    chk("t1_valid",  {31'd0, p0_resp_valid_o}, 32'd1);
    chk("t1_result", p0_result_o, 32'd12);
    chk("t1_zero",   {31'd0, p0_zero_o}, 32'd0);
    chk("t1_err",    {31'd0, p0_err_o}, 32'd0);
    chk("t1_p1_silent", {31'd0, p1_resp_valid_o}, 32'd0);
    chk("t1_p1_result", p1_result_o, 32'd0);
    step();
    chk("t1_drained", {31'd0, p0_resp_valid_o}, 32'd0);

    // Both ports every cycle; port 0 won last, so port 1 wins the first tie
    p0_src1_i = 32'd9;    p0_src2_i = 32'd9;    p0_ctrl_i = 4'b0110;
    p1_src1_i = 32'hF0;   p1_src2_i = 32'h0F;   p1_ctrl_i = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        p0_req_valid_i = 1'b1; p1_req_valid_i = 1'b1;
        exp_g = (k % 2 == 0) ? 1'b1 : 1'b0;
        #1;
        chk($sformatf("t2_p0_ready_%0d", k), {31'd0, p0_req_ready_o}, {31'd0, ~exp_g});
        chk($sformatf("t2_p1_ready_%0d", k), {31'd0, p1_req_ready_o}, {31'd0, exp_g});
      end else begin
        p0_req_valid_i = 1'b0; p1_req_valid_i = 1'b0;
      end
      step();
      if (k >= 1) begin
        exp_g = ((k - 1) % 2 == 0) ? 1'b1 : 1'b0;
        chk($sformatf("t2_p0_rv_%0d", k), {31'd0, p0_resp_valid_o}, {31'd0, ~exp_g});
        chk($sformatf("t2_p1_rv_%0d", k), {31'd0, p1_resp_valid_o}, {31'd0, exp_g});
        if (exp_g) begin
          chk($sformatf("t2_p1_res_%0d", k), p1_result_o, 32'hFF);
          chk($sformatf("t2_p1_zero_%0d", k), {31'd0, p1_zero_o}, 32'd0);
        end else begin
          chk($sformatf("t2_p0_res_%0d", k), p0_result_o, 32'd0);
          chk($sformatf("t2_p0_zero_%0d", k), {31'd0, p0_zero_o}, 32'd1);
        end
      end
    end
    step();

    // Stall: p1 response held while a p0 op waits in E
    p1_resp_ready_i = 1'b0;
    p1_req_valid_i = 1'b1; p1_src1_i = 32'd1; p1_src2_i = 32'd2; p1_ctrl_i = 4'b0010;
    #1;
    chk("t3_p1_ready", {31'd0, p1_req_ready_o}, 32'd1);
    step();
    p1_req_valid_i = 1'b0;
    p0_req_valid_i = 1'b1; p0_src1_i = 32'd10; p0_src2_i = 32'd20; p0_ctrl_i = 4'b0010;
    #1;
    chk("t3_p0_ready", {31'd0, p0_req_ready_o}, 32'd1);
    step();
    p0_src1_i = 32'd100; p0_src2_i = 32'd1;
    p1_req_valid_i = 1'b1; p1_src1_i = 32'd50; p1_src2_i = 32'd8; p1_ctrl_i = 4'b0110;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("t3_stall_p0_ready_%0d", s), {31'd0, p0_req_ready_o}, 32'd0);
      chk($sformatf("t3_stall_p1_ready_%0d", s), {31'd0, p1_req_ready_o}, 32'd0);
      chk($sformatf("t3_stall_p1_rv_%0d", s), {31'd0, p1_resp_valid_o}, 32'd1);
      chk($sformatf("t3_stall_p1_res_%0d", s), p1_result_o, 32'd3);
      chk($sformatf("t3_stall_p0_rv_%0d", s), {31'd0, p0_resp_valid_o}, 32'd0);
      step();
    end
    p0_req_valid_i = 1'b0; p1_req_valid_i = 1'b0;
    p1_resp_ready_i = 1'b1;
    #1;
    chk("t3_rel_p1_rv", {31'd0, p1_resp_valid_o}, 32'd1);
    step();
    chk("t3_drain_p0_rv",  {31'd0, p0_resp_valid_o}, 32'd1);
    chk("t3_drain_p0_res", p0_result_o, 32'd30);
    chk("t3_drain_p1_rv",  {31'd0, p1_resp_valid_o}, 32'd0);
    step();
    chk("t3_empty_p0_rv", {31'd0, p0_resp_valid_o}, 32'd0);

    // Illegal ctrl on p1, then legal ADD with the same operands
    p1_req_valid_i = 1'b1; p1_src1_i = 32'd3; p1_src2_i = 32'd4; p1_ctrl_i = 4'b1111;
    #1;
    chk("t4_ill_ready", {31'd0, p1_req_ready_o}, 32'd1);
    step();
    p1_ctrl_i = 4'b0010;
    #1;
    chk("t4_add_ready", {31'd0, p1_req_ready_o}, 32'd1);
    step();
    p1_req_valid_i = 1'b0;
    chk("t4_ill_rv",   {31'd0, p1_resp_valid_o}, 32'd1);
    chk("t4_ill_res",  p1_result_o, 32'd0);
    chk("t4_ill_zero", {31'd0, p1_zero_o}, 32'd1);
    chk("t4_ill_err",  {31'd0, p1_err_o}, 32'd1);
    step();
    chk("t4_add_rv",   {31'd0, p1_resp_valid_o}, 32'd1);
    chk("t4_add_res",  p1_result_o, 32'd7);
    chk("t4_add_zero", {31'd0, p1_zero_o}, 32'd0);
    chk("t4_add_err",  {31'd0, p1_err_o}, 32'd0);
    step();

    // Signed SLT in both directions
    p0_req_valid_i = 1'b1; p0_src1_i = 32'hFFFF_FFFF; p0_src2_i = 32'd1; p0_ctrl_i = 4'b0111;
    step();
    p0_src1_i = 32'd1; p0_src2_i = 32'hFFFF_FFFF;
    step();
    p0_req_valid_i = 1'b0;
    chk("t5_slt_a_res",  p0_result_o, 32'd1);
    chk("t5_slt_a_zero", {31'd0, p0_zero_o}, 32'd0);
    step();
    chk("t5_slt_b_rv",   {31'd0, p0_resp_valid_o}, 32'd1);
    chk("t5_slt_b_res",  p0_result_o, 32'd0);
    chk("t5_slt_b_zero", {31'd0, p0_zero_o}, 32'd1);
    chk("t5_slt_b_err",  {31'd0, p0_err_o}, 32'd0);
    step();

    // Reset while E and W both hold operations
    p0_resp_ready_i = 1'b0;
    p0_req_valid_i = 1'b1; p0_src1_i = 32'd2; p0_src2_i = 32'd2; p0_ctrl_i = 4'b0010;
    step();
    p0_req_valid_i = 1'b0;
    p1_req_valid_i = 1'b1; p1_src1_i = 32'd1; p1_src2_i = 32'd1; p1_ctrl_i = 4'b0010;
    #1;
    chk("t6_p1_ready", {31'd0, p1_req_ready_o}, 32'd1);
    step();
    p1_req_valid_i = 1'b0;
    chk("t6_pre_p0_rv", {31'd0, p0_resp_valid_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("t6_rst_p0_rv",  {31'd0, p0_resp_valid_o}, 32'd0);
    chk("t6_rst_p1_rv",  {31'd0, p1_resp_valid_o}, 32'd0);
    chk("t6_rst_p0_res", p0_result_o, 32'd0);
    #4;
    rst_i = 1'b1;
    p0_resp_ready_i = 1'b1;
    step();
    chk("t6_post_p1_rv", {31'd0, p1_resp_valid_o}, 32'd0);
    p0_req_valid_i = 1'b1; p1_req_valid_i = 1'b1;
    #1;
    chk("t6_tie_p0_ready", {31'd0, p0_req_ready_o}, 32'd1);
    chk("t6_tie_p1_ready", {31'd0, p1_req_ready_o}, 32'd0);
    step();
    p0_req_valid_i = 1'b0; p1_req_valid_i = 1'b0;
    chk("t6_flush_p1_rv", {31'd0, p1_resp_valid_o}, 32'd0);
    step();
    chk("t6_new_p0_rv",  {31'd0, p0_resp_valid_o}, 32'd1);
    chk("t6_new_p0_res", p0_result_o, 32'd4);
    chk("t6_new_p1_rv",  {31'd0, p1_resp_valid_o}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
